// File: rtl/h264dc_pkg.sv
// Shared types and constants for the H.264 DC Hadamard transform.
package h264dc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHpass,
        StVpass,
        StDrain
    } state_e;

    typedef enum logic {
        MODE_2X2 = 1'b0,
        MODE_4X4 = 1'b1
    } mode_e;

    localparam int unsigned N2 = 4;
    localparam int unsigned N4 = 16;

endpackage

// File: rtl/h264dc_butterfly4.sv
// Combinational 4-point Hadamard butterfly, or two independent 2-point
// butterflies when pair_i is set ({a,b} and {c,d}).
module h264dc_butterfly4 #(
    parameter int W = 16
) (
    input  logic                pair_i,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] c_i,
    input  logic signed [W-1:0] d_i,
    output logic signed [W+1:0] y0_o,
    output logic signed [W+1:0] y1_o,
    output logic signed [W+1:0] y2_o,
    output logic signed [W+1:0] y3_o
);

    logic signed [W+1:0] ea, eb, ec, ed;
    logic signed [W+1:0] s0, d0, s1, d1;

    // Two guard bits keep a sum of four W-bit operands from overflowing.
    always_comb begin
        ea = {{2{a_i[W-1]}}, a_i};
        eb = {{2{b_i[W-1]}}, b_i};
        ec = {{2{c_i[W-1]}}, c_i};
        ed = {{2{d_i[W-1]}}, d_i};
        s0 = ea + eb;
        d0 = ea - eb;
        s1 = ec + ed;
        d1 = ec - ed;
        if (pair_i) begin
            y0_o = s0;
            y1_o = d0;
            y2_o = s1;
            y3_o = d1;
        end else begin
            // Rows of H: [1 1 1 1], [1 1 -1 -1], [1 -1 -1 1], [1 -1 1 -1]
            y0_o = s0 + s1;
            y1_o = s0 - s1;
            y2_o = d0 - d1;
            y3_o = d0 + d1;
        end
    end

endmodule

// File: rtl/h264dc_hadamard.sv
// H.264 DC Hadamard transform: loads a 2x2 or 4x4 block in raster order, runs
// a row pass and a column pass, then drains coefficients under READYO.
module h264dc_hadamard
    import h264dc_pkg::*;
#(
    parameter int  IW       = 16,
    parameter bit  TOGETHER = 1'b0,
    localparam int OW       = IW + 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          MODE,
    input  logic          ENABLE,
    input  logic [IW-1:0] XXIN,
    output logic          READYI,
    output logic          VALID,
    output logic [OW-1:0] YYOUT,
    input  logic          READYO,
    output logic          BUSY
);

    state_e        state_q;
    mode_e         mode_q;
    logic [3:0]    cnt_q;
    logic [3:0]    idx_q;
    logic          valid_q;
    logic [OW-1:0] yy_q;

    // Block storage: samples, then row results, then final coefficients.
    logic signed [OW-1:0]   m_q   [16];
    logic signed [IW+1:0]   row_y [16];
    logic        [IW+1:0]   col_a [16];
    logic signed [IW+3:0]   col_y [16];
    logic        [OW-1:0]   res   [16];
    logic                   unused_lsb;

    logic       accept;
    logic       emit;
    logic [3:0] n_last;

    // Handshake and drain decode.
    always_comb begin
        READYI = (state_q == StIdle) || (state_q == StLoad);
        BUSY   = (state_q != StIdle);
        accept = ENABLE && READYI;
        n_last = (mode_q == MODE_4X4) ? 4'(N4 - 1) : 4'(N2 - 1);
        emit   = (state_q == StDrain) && (READYO || (TOGETHER && (idx_q != 4'd0)));
    end

    // Row pass: one butterfly per row; row 0 doubles as the 2x2 row pass.
    for (genvar r = 0; r < 4; r++) begin : g_row
        h264dc_butterfly4 #(.W(IW)) u_row (
            .pair_i (mode_q == MODE_2X2),
            .a_i    (m_q[4*r+0][IW-1:0]),
            .b_i    (m_q[4*r+1][IW-1:0]),
            .c_i    (m_q[4*r+2][IW-1:0]),
            .d_i    (m_q[4*r+3][IW-1:0]),
            .y0_o   (row_y[4*r+0]),
            .y1_o   (row_y[4*r+1]),
            .y2_o   (row_y[4*r+2]),
            .y3_o   (row_y[4*r+3])
        );
    end

    // Column operand routing; in 2x2 column unit 0 pairs (r0,r2) and (r1,r3).
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                col_a[4*c+k] = m_q[4*k+c][IW+1:0];
            end
        end
        if (mode_q == MODE_2X2) begin
            col_a[1] = m_q[2][IW+1:0];
            col_a[2] = m_q[1][IW+1:0];
            col_a[3] = m_q[3][IW+1:0];
        end
    end

    // Column pass: one butterfly per column.
    for (genvar c = 0; c < 4; c++) begin : g_col
        h264dc_butterfly4 #(.W(IW + 2)) u_col (
            .pair_i (mode_q == MODE_2X2),
            .a_i    (col_a[4*c+0]),
            .b_i    (col_a[4*c+1]),
            .c_i    (col_a[4*c+2]),
            .d_i    (col_a[4*c+3]),
            .y0_o   (col_y[4*c+0]),
            .y1_o   (col_y[4*c+1]),
            .y2_o   (col_y[4*c+2]),
            .y3_o   (col_y[4*c+3])
        );
    end

    // Final coefficients: 4x4 drops the LSB (floor shift), 2x2 is unshifted.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                res[4*k+c] = col_y[4*c+k][IW+3:1];
            end
        end
        if (mode_q == MODE_2X2) begin
            res[0] = col_y[0][OW-1:0];
            res[1] = col_y[2][OW-1:0];
            res[2] = col_y[1][OW-1:0];
            res[3] = col_y[3][OW-1:0];
        end
        unused_lsb = 1'b0;
        for (int i = 4; i < 16; i++) begin
            unused_lsb = unused_lsb ^ col_y[i][0];
        end
    end

    // Block storage; always fully overwritten before use, so no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            m_q[cnt_q] <= {{3{XXIN[IW-1]}}, XXIN};
        end else if (state_q == StHpass) begin
            for (int i = 0; i < 16; i++) begin
                m_q[i] <= {row_y[i][IW+1], row_y[i]};
            end
        end else if (state_q == StVpass) begin
            for (int i = 0; i < 16; i++) begin
                m_q[i] <= res[i];
            end
        end
    end

    // Control FSM, counters and registered output.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            mode_q  <= MODE_2X2;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            yy_q    <= '0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                yy_q <= m_q[idx_q];
            end
            unique case (state_q)
                StIdle: begin
                    if (ENABLE) begin
                        mode_q  <= mode_e'(MODE);
                        cnt_q   <= 4'd1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (ENABLE) begin
                        if (cnt_q == n_last) begin
                            cnt_q   <= 4'd0;
                            state_q <= StHpass;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StHpass: state_q <= StVpass;
                StVpass: begin
                    idx_q   <= 4'd0;
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (emit) begin
                        if (idx_q == n_last) begin
                            idx_q   <= 4'd0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign VALID = valid_q;
    assign YYOUT = yy_q;

endmodule

// File: tb/tb_h264dc_hadamard.sv
// Scoreboard bench: two instances (TOGETHER=0 and TOGETHER=1) share stimulus;
// expected coefficients come from a direct matrix model.
module tb_h264dc_hadamard;

    localparam int IW = 16;
    localparam int OW = IW + 3;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          MODE;
    logic          ENABLE;
    logic [IW-1:0] XXIN;
    logic          READYO;

    logic          readyi0, valid0, busy0;
    logic [OW-1:0] yy0;
    logic          readyi1, valid1, busy1;
    logic [OW-1:0] yy1;

    always #5 CLK = ~CLK;

    h264dc_hadamard #(.IW(IW), .TOGETHER(1'b0)) dut0 (
        .CLK    (CLK),
        .RESET  (RESET),
        .MODE   (MODE),
        .ENABLE (ENABLE),
        .XXIN   (XXIN),
        .READYI (readyi0),
        .VALID  (valid0),
        .YYOUT  (yy0),
        .READYO (READYO),
        .BUSY   (busy0)
    );

    h264dc_hadamard #(.IW(IW), .TOGETHER(1'b1)) dut1 (
        .CLK    (CLK),
        .RESET  (RESET),
        .MODE   (MODE),
        .ENABLE (ENABLE),
        .XXIN   (XXIN),
        .READYI (readyi1),
        .VALID  (valid1),
        .YYOUT  (yy1),
        .READYO (READYO),
        .BUSY   (busy1)
    );

    int errors = 0;
    int checks = 0;
    int q0[$];
    int q1[$];
    int cyc = 0;
    int t_last = 0;
    bit lat_arm = 1'b0;
    bit b2b_arm = 1'b0;
    int last_v1 = 0;
    int nv0 = 0;
    int nv1 = 0;
    logic ro_last = 1'b1;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int hsign(input int n, input int u, input int i);
        int h4[4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
        if (n == 2) return (u == 1 && i == 1) ? -1 : 1;
        return h4[u][i];
    endfunction

    function automatic int coef(input bit is4, input int u, input int v, input int x[16]);
        int n = is4 ? 4 : 2;
        int s = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                s += hsign(n, u, i) * hsign(n, v, j) * x[i*n+j];
        return is4 ? (s >>> 1) : s;
    endfunction

    always @(posedge CLK) cyc++;

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (valid0) begin
            nv0++;
            if (q0.size() == 0) check_val("dut0_unexpected_valid", 1, 0);
            else check_val("dut0_coef", $signed(yy0), q0.pop_front());
            check_val("dut0_readyo_gate", int'(ro_last), 1);
            if (lat_arm) begin
                check_val("first_valid_latency", cyc - (t_last - 1), 4);
                lat_arm = 1'b0;
            end
        end
        if (valid1) begin
            if (q1.size() == 0) check_val("dut1_unexpected_valid", 1, 0);
            else check_val("dut1_coef", $signed(yy1), q1.pop_front());
            if (b2b_arm) begin
                if (nv1 > 0) check_val("dut1_back_to_back", cyc - last_v1, 1);
                last_v1 = cyc;
            end
            nv1++;
        end
        ro_last = READYO;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive_sample(input logic m, input int v);
        int n = 0;
        while (!(readyi0 && readyi1) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_val("readyi_timeout", 0, 1);
        MODE   = m;
        XXIN   = v[IW-1:0];
        ENABLE = 1'b1;
        tick();
        ENABLE = 1'b0;
    endtask

    task automatic run_block(input bit is4, input bit toggle_mode, input int x[16]);
        int n = is4 ? 4 : 2;
        for (int u = 0; u < n; u++)
            for (int v = 0; v < n; v++) begin
                q0.push_back(coef(is4, u, v, x));
                q1.push_back(coef(is4, u, v, x));
            end
        for (int i = 0; i < n * n; i++)
            drive_sample((toggle_mode && i > 0) ? !is4 : is4, x[i]);
        t_last = cyc;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check_val("drain_timeout", q0.size() + q1.size(), 0);
        repeat (3) tick();
    endtask

    int x[16];
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        RESET = 1'b0; MODE = 1'b0; ENABLE = 1'b0; XXIN = '0; READYO = 1'b1;
        #12;
        check_val("reset_readyi", int'(readyi0), 1);
        check_val("reset_valid", int'(valid0), 0);
        check_val("reset_busy", int'(busy0), 0);
        check_val("reset_yyout", int'(yy0), 0);
        tick();
        RESET = 1'b1;
        tick();

        // 2x2 basic with latency check
        x = '{default: 0};
        x[0] = 1; x[1] = 2; x[2] = 3; x[3] = 4;
        lat_arm = 1'b1;
        run_block(1'b0, 1'b0, x);
        check_val("busy_after_load", int'(busy0), 1);
        check_val("readyi_after_load", int'(readyi0), 0);
        wait_drain();
        check_val("latency_seen", int'(lat_arm), 0);
        check_val("idle_readyi", int'(readyi0), 1);

        // 4x4 flat, impulse, and most negative input
        x = '{default: 5};
        run_block(1'b1, 1'b0, x);
        wait_drain();
        x = '{default: 0};
        x[0] = 8;
        run_block(1'b1, 1'b0, x);
        wait_drain();
        x = '{default: -32768};
        run_block(1'b1, 1'b0, x);
        wait_drain();

        // READYO stall pattern during DRAIN
        READYO = 1'b0;
        x = '{default: 0};
        x[0] = 7; x[1] = -3; x[2] = 2; x[3] = 5;
        run_block(1'b0, 1'b0, x);
        nv0 = 0; nv1 = 0; b2b_arm = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            READYO = pat[i][0];
            tick();
        end
        READYO = 1'b0;
        tick();
        tick();
        check_val("dut0_pulses", nv0, 4);
        check_val("dut1_pulses", nv1, 4);
        b2b_arm = 1'b0;
        READYO = 1'b1;
        wait_drain();

        // Reset mid-load abort, then a fresh 2x2 block
        for (int i = 0; i < 7; i++) drive_sample(1'b1, 100 + i);
        RESET = 1'b0;
        tick();
        check_val("abort_busy", int'(busy0), 0);
        check_val("abort_readyi", int'(readyi0), 1);
        check_val("abort_valid", int'(valid0), 0);
        tick();
        RESET = 1'b1;
        repeat (20) tick();
        x = '{default: 0};
        x[0] = 1; x[1] = 2; x[2] = 3; x[3] = 4;
        run_block(1'b0, 1'b0, x);
        wait_drain();

        // MODE changes after the first sample must be ignored
        for (int i = 0; i < 16; i++) x[i] = i * 3 - 20;
        run_block(1'b1, 1'b1, x);
        wait_drain();

        check_val("q0_empty", q0.size(), 0);
        check_val("q1_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/h264dc_hadamard.md
H264DC_HADAMARD -- requirements
Module: h264dc_hadamard

Interface
REQ-001 SHALL have parameter IW, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter TOGETHER, default 0; 1 means a started output block drains without READYO gaps.
REQ-003 SHALL have derived localparam OW = IW+3, output width.
REQ-004 SHALL have port CLK  input  1  the single clock, rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port MODE  input  1  block size: 0 = 2x2 chroma DC, 1 = 4x4 luma DC.
REQ-007 SHALL have port ENABLE  input  1  XXIN valid this cycle.
REQ-008 SHALL have port XXIN  input  IW  input sample, raster-scan order.
REQ-009 SHALL have port READYI  output  1  block can accept a sample.
REQ-010 SHALL have port VALID  output  1  YYOUT valid this cycle.
REQ-011 SHALL have port YYOUT  output  OW  coefficient, raster-scan order, signed.
REQ-012 SHALL have port READYO  input  1  downstream can take the next coefficient.
REQ-013 SHALL have port BUSY  output  1  a block is held in any state except IDLE.

Function
REQ-014 SHALL implement the state machine IDLE -> LOAD -> HPASS -> VPASS -> DRAIN -> IDLE.
REQ-015 SHALL define block size N as 4 samples when MODE=0 and 16 samples when MODE=1.
REQ-016 SHALL accept a sample when ENABLE=1 and READYI=1, with READYI=1 only in IDLE and LOAD.
REQ-017 SHALL latch MODE on the first accepted sample and ignore MODE changes until the block returns to IDLE.
REQ-018 SHALL store the first accepted sample, move IDLE->LOAD, and keep a sample counter that wraps to 0 at N.
REQ-019 SHALL move LOAD->HPASS on the cycle the N-th sample is accepted; ENABLE=0 in LOAD holds the state.
REQ-020 HPASS (1 cycle) SHALL apply the row butterfly to every row: 2-point [a+b, a-b] for 2x2, or 4-point H for 4x4.
REQ-021 For 4x4, H SHALL be rows [1 1 1 1], [1 1 -1 -1], [1 -1 -1 1], [1 -1 1 -1].
REQ-022 VPASS (1 cycle) SHALL apply the same butterfly down every column.
REQ-023 4x4 results SHALL be arithmetic-shifted right by 1 (floor); 2x2 results SHALL be unshifted.
REQ-024 All results SHALL be sign-extended to OW, and no intermediate SHALL overflow (row stage IW+2 bits, column stage IW+4 bits before the shift).
REQ-025 DRAIN SHALL emit one coefficient per emit cycle in raster order.
REQ-026 An emit cycle SHALL be a DRAIN cycle with READYO=1, or with TOGETHER=1 and the output index not 0.
REQ-027 VALID and YYOUT SHALL be registered and appear on the cycle after the emit cycle.
REQ-028 VALID SHALL be 0 in every other cycle, and YYOUT SHALL hold its last value while VALID=0.
REQ-029 After the N-th emit, the FSM SHALL go to IDLE and READYI SHALL rise on the next cycle.
REQ-030 Minimum latency SHALL be 4 cycles from the last-sample-accepted edge to the first VALID=1, with READYO held at 1.
REQ-031 READYO=0 in DRAIN SHALL stall without losing or repeating coefficients; with TOGETHER=1 it only gates the first coefficient.

Reset
REQ-032 RESET=0 SHALL asynchronously force state IDLE, counters 0, READYI=1, VALID=0, YYOUT=0 and BUSY=0.
REQ-033 Reset in any state SHALL discard the partial or complete block and produce no VALID after release.
REQ-034 Sample registers SHALL need no reset; every block fully overwrites them before use.

Structure
REQ-035 Package h264dc_pkg SHALL hold the state enum, the mode enum (MODE_2X2, MODE_4X4) and constants N2=4 and N4=16.
REQ-036 A combinational sub-module h264dc_butterfly4 (4-point H, parameterised input width, with a 2-point mode) SHALL be instanced for the row and column passes.

Verification
REQ-037 MODE=0, IW=16, inputs 1,2,3,4, READYO=1 -> YYOUT 10,-2,-4,0 with VALID on 4 consecutive cycles, first VALID 4 cycles after the last input.
REQ-038 MODE=1, all 16 inputs 5 -> 40 then fifteen 0s; a second test with only x00=8 (others 0) -> sixteen 4s.
REQ-039 MODE=1, all 16 inputs -32768 -> first coefficient -262144 (0x40000 in 19 bits), remaining 15 are 0, with no overflow.
REQ-040 MODE=0, READYO toggled 1,0,0,1,0,1,1 during DRAIN with TOGETHER=0 -> exactly 4 VALID pulses in order and none while READYO=0; with TOGETHER=1 -> after the first emit, 3 VALID on back-to-back cycles despite READYO=0.
REQ-041 RESET pulsed low after 7 of 16 samples (MODE=1), then a fresh 2x2 block 1,2,3,4 -> no VALID from the aborted block, then 10,-2,-4,0.
REQ-042 MODE toggled after the first sample of a 4x4 block -> the block still takes 16 samples and outputs 4x4 results.
